alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Control-side driver of the datapath ALU: accepts an operation request, decodes it into the ALU's one-hot operation vector, and presents operands.
- Holds the operation for the required number of cycles: 1 for combinational ops, DIV_CYCLES for the iterative divider.
- Captures the 64-bit ALU result into HI/LO result registers and signals completion.
- Sits between the control unit and the ALU and owns the timing of every ALU operation.

Parameters:
- DIV_CYCLES, 33, cycles the DIV bit is held asserted before the result is sampled (divider iterations + 1); legal range 2..63.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request strobe; sampled only while busy=0
- opcode  in  5  operation code (map below)
- a  in  32  operand A
- b  in  32  operand B
- busy  out  1  high from the cycle after accept until done
- alu_opp  out  16  one-hot ALU operation vector
- x  out  32  ALU operand x
- y  out  32  ALU operand y
- z  in  64  ALU result
- done  out  1  one-cycle completion pulse
- illegal  out  1  valid with done; opcode unmapped
- result_lo  out  32  captured z[31:0]
- result_hi  out  32  captured z[63:32]

Behaviour:
- Reset (async, immediate): state=IDLE; busy, done, illegal=0; alu_opp=0 (this also holds the divider in reset); x, y, result_lo, result_hi=0; cycle counter=0.
- Opcode to alu_opp bit:
  - 00000 ADD->0, 00001 SUB->1, 00010 NEG->2, 00011 MUL->3, 00100 DIV->4
  - 00101 AND->5, 00110 OR->6, 00111 ROR->7, 01000 ROL->8
  - 01001 SLL->9, 01010 SRA->10, 01011 SRL->11, 01100 NOT->12, 01101 INC->13
  - 01110..11111 illegal. Bits 14,15 are never driven high.
- States: IDLE, EXEC, WAIT_DIV.
- IDLE:
  - start=1 at an edge: latch a->x, b->y, load decoded one-hot into alu_opp, busy<=1.
  - Next state EXEC for non-DIV ops; WAIT_DIV with counter=DIV_CYCLES-1 for DIV.
  - Illegal opcode: no state change, alu_opp stays 0, done<=1 and illegal<=1 for one cycle, results unchanged.
  - start=0: remain in IDLE.
- EXEC (exactly one cycle): at the next edge, result_lo<=z[31:0], result_hi<=z[63:32], done<=1, busy<=0, alu_opp<=0, state IDLE.
- WAIT_DIV:
  - DIV bit held high continuously; counter decrements each edge.
  - At the edge where counter==0: capture z as in EXEC, done<=1, busy<=0, alu_opp<=0, state IDLE.
- Latency (start edge to done high):
  - 2 edges for single-cycle ops; done is visible in the cycle after EXEC.
  - DIV_CYCLES+1 edges for DIV.
- x, y and alu_opp are stable for the whole operation; alu_opp is zero in IDLE.
- done and illegal are registered single-cycle pulses. illegal=0 whenever done marks a legal op.
- Back-to-back: start may be asserted in the same cycle done is high (busy=0 then); it is accepted and x/y/alu_opp reload at that edge.
- start while busy=1: ignored entirely; no queuing.
- Results are held until the next legal completion.
- Opcode/a/b changes while busy: no effect.
- Reset asserted mid-DIV: everything clears immediately, DIV bit drops, no done is produced; the first op after reset release behaves normally.

Test Plan:
- ADD: a=10, b=5, opcode 00000 -> alu_opp=0x0001 during EXEC; done 2 edges after start; result_lo=15, result_hi=0; busy low with done.
- MUL: a=0xFFFFFFFF, b=2 (ALU unsigned behaviour modelled) -> alu_opp=0x0008; {result_hi,result_lo} equals the captured z; latency 2.
- DIV: a=20, b=5, DIV_CYCLES=33 -> alu_opp=0x0010 held for exactly 33 cycles; done at edge 34; result_lo=4, result_hi=0; alu_opp=0 in the cycle done is high.
- Illegal: opcode 10101 -> done=1 and illegal=1 one edge after start; alu_opp never nonzero; result registers unchanged from the prior op.
- Back-to-back plus busy guard:
  - NOT a=0xAAAAAAAA, then SLL a=1 issued in the done cycle -> result_lo=0x55555555, then 2.
  - A start pulse during a DIV is ignored (no extra done).
- Reset mid-DIV: assert reset at cycle 10 of a DIV -> alu_opp, busy, done, x, y and results=0 immediately, no done afterwards; a subsequent ADD 3+4 yields 7 with normal latency.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: decodes a requested opcode into the ALU one-hot
// operation vector, presents operands and holds them for the operation's
// duration, then captures the 64-bit ALU result into HI/LO registers.
module alu_op_sequencer #(
   parameter int unsigned DIV_CYCLES = 33
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [4:0]  opcode,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [15:0] alu_opp,
   output logic [31:0] x,
   output logic [31:0] y,
   input  logic [63:0] z,
   output logic        done,
   output logic        illegal,
   output logic [31:0] result_lo,
   output logic [31:0] result_hi
);

   typedef enum logic [1:0] {StIdle, StExec, StWaitDiv} state_e;

   localparam int unsigned CntW = 6;
   // Counter preload: the DIV bit stays high for DIV_CYCLES cycles in total.
   localparam logic [CntW-1:0] DivLoad = CntW'(DIV_CYCLES - 1);

   localparam logic [4:0] OpAdd = 5'b00000;
   localparam logic [4:0] OpSub = 5'b00001;
   localparam logic [4:0] OpNeg = 5'b00010;
   localparam logic [4:0] OpMul = 5'b00011;
   localparam logic [4:0] OpDiv = 5'b00100;
   localparam logic [4:0] OpAnd = 5'b00101;
   localparam logic [4:0] OpOr  = 5'b00110;
   localparam logic [4:0] OpRor = 5'b00111;
   localparam logic [4:0] OpRol = 5'b01000;
   localparam logic [4:0] OpSll = 5'b01001;
   localparam logic [4:0] OpSra = 5'b01010;
   localparam logic [4:0] OpSrl = 5'b01011;
   localparam logic [4:0] OpNot = 5'b01100;
   localparam logic [4:0] OpInc = 5'b01101;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            illegal_q, illegal_d;
   logic [15:0]     opp_q, opp_d;
   logic [31:0]     x_q, x_d;
   logic [31:0]     y_q, y_d;
   logic [31:0]     lo_q, lo_d;
   logic [31:0]     hi_q, hi_d;

   logic [15:0]     dec_opp;
   logic            dec_legal;
   logic            dec_div;

   // Opcode decode into the ALU one-hot vector; bits 14 and 15 are never used.
   always_comb begin
      dec_opp   = 16'h0000;
      dec_legal = 1'b1;
      unique case (opcode)
         OpAdd:   dec_opp = 16'h0001;
         OpSub:   dec_opp = 16'h0002;
         OpNeg:   dec_opp = 16'h0004;
         OpMul:   dec_opp = 16'h0008;
         OpDiv:   dec_opp = 16'h0010;
         OpAnd:   dec_opp = 16'h0020;
         OpOr:    dec_opp = 16'h0040;
         OpRor:   dec_opp = 16'h0080;
         OpRol:   dec_opp = 16'h0100;
         OpSll:   dec_opp = 16'h0200;
         OpSra:   dec_opp = 16'h0400;
         OpSrl:   dec_opp = 16'h0800;
         OpNot:   dec_opp = 16'h1000;
         OpInc:   dec_opp = 16'h2000;
         default: dec_legal = 1'b0;
      endcase
      dec_div = (opcode == OpDiv);
   end

   // Next-state logic: accept in idle, single-cycle execute, or count out the divider.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      illegal_d = 1'b0;
      opp_d     = opp_q;
      x_d       = x_q;
      y_d       = y_q;
      lo_d      = lo_q;
      hi_d      = hi_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (dec_legal) begin
                  x_d    = a;
                  y_d    = b;
                  opp_d  = dec_opp;
                  busy_d = 1'b1;
                  if (dec_div) begin
                     state_d = StWaitDiv;
                     cnt_d   = DivLoad;
                  end else begin
                     state_d = StExec;
                  end
               end else begin
                  // Rejected without touching the ALU or the result registers.
                  done_d    = 1'b1;
                  illegal_d = 1'b1;
               end
            end
         end

         StExec: begin
            lo_d    = z[31:0];
            hi_d    = z[63:32];
            done_d  = 1'b1;
            busy_d  = 1'b0;
            opp_d   = 16'h0000;
            state_d = StIdle;
         end

         StWaitDiv: begin
            if (cnt_q == '0) begin
               lo_d    = z[31:0];
               hi_d    = z[63:32];
               done_d  = 1'b1;
               busy_d  = 1'b0;
               opp_d   = 16'h0000;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
            opp_d   = 16'h0000;
         end
      endcase
   end

   // State and datapath registers; reset also drops alu_opp, holding the divider in reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         opp_q     <= 16'h0000;
         x_q       <= 32'h0;
         y_q       <= 32'h0;
         lo_q      <= 32'h0;
         hi_q      <= 32'h0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         illegal_q <= illegal_d;
         opp_q     <= opp_d;
         x_q       <= x_d;
         y_q       <= y_d;
         lo_q      <= lo_d;
         hi_q      <= hi_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign illegal   = illegal_q;
   assign alu_opp   = opp_q;
   assign x         = x_q;
   assign y         = y_q;
   assign result_lo = lo_q;
   assign result_hi = hi_q;

endmodule
